// File: rtl/spi_master_arbiter_if.sv
// Requester-side handshake and SPI pin bundle for spi_master_arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus the SPI peripheral.
interface spi_master_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req_i;
   logic [8*NREQ-1:0] tx_data_i;
   logic [NREQ-1:0]   tx_last_i;
   logic [NREQ-1:0]   tx_ack_o;
   logic [NREQ-1:0]   gnt_o;
   logic [7:0]        rx_data_o;
   logic [NREQ-1:0]   rx_valid_o;
   logic              busy_o;
   logic              sclk_o;
   logic              ss_o;
   logic              sdo_o;
   logic              sdi_i;

   modport master (
      input  req_i, tx_data_i, tx_last_i, sdi_i,
      output tx_ack_o, gnt_o, rx_data_o, rx_valid_o, busy_o, sclk_o, ss_o, sdo_o
   );

   modport slave (
      output req_i, tx_data_i, tx_last_i, sdi_i,
      input  tx_ack_o, gnt_o, rx_data_o, rx_valid_o, busy_o, sclk_o, ss_o, sdo_o
   );
endinterface

// File: rtl/spi_master_arbiter.sv
// Mode-0 SPI master shared by NREQ requesters under round-robin arbitration.
// A granted requester keeps the bus until it presents a byte flagged last.
module spi_master_arbiter #(
   parameter int NREQ    = 4,
   parameter int CLK_DIV = 4,
   parameter int SS_GAP  = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   spi_master_arbiter_if.master bus
);
   localparam int          PW     = $clog2(NREQ);
   localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_M1 = 16'(SS_GAP - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_END, S_GAP} state_t;

   state_t          state, state_n;
   logic [15:0]     cnt, cnt_n;
   logic [2:0]      bit_cnt, bit_n;
   logic [6:0]      tx_sh, tx_sh_n;
   logic [7:0]      rx_sh, rx_sh_n, rx_data, rx_data_n;
   logic            last, last_n;
   logic [PW-1:0]   gidx, gidx_n, ptr, ptr_n, win, src;
   logic            found;
   logic [NREQ-1:0] gnt, gnt_n, tx_ack, tx_ack_n, rx_valid, rx_valid_n;
   logic            sclk, sclk_n, ss, ss_n, sdo, sdo_n, busy, busy_n;
   logic [7:0]      sel_data;
   logic            sel_last;

   // First pending requester at or after the pointer, wrapping.
   always_comb begin
      found = 1'b0;
      win   = ptr;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && bus.req_i[(int'(ptr) + i) % NREQ]) begin
            found = 1'b1;
            win   = PW'((int'(ptr) + i) % NREQ);
         end
      end
   end

   assign src      = (state == S_IDLE) ? win : gidx;
   assign sel_data = bus.tx_data_i[8*int'(src) +: 8];
   assign sel_last = bus.tx_last_i[src];

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      bit_n      = bit_cnt;
      tx_sh_n    = tx_sh;
      rx_sh_n    = rx_sh;
      rx_data_n  = rx_data;
      last_n     = last;
      gidx_n     = gidx;
      ptr_n      = ptr;
      gnt_n      = gnt;
      tx_ack_n   = '0;
      rx_valid_n = '0;
      sclk_n     = sclk;
      ss_n       = ss;
      sdo_n      = sdo;
      busy_n     = busy;
      unique case (state)
         S_IDLE: begin
            ss_n   = 1'b1;
            sclk_n = 1'b0;
            if (found) begin
               gidx_n        = win;
               gnt_n         = '0;
               gnt_n[win]    = 1'b1;
               ss_n          = 1'b0;
               busy_n        = 1'b1;
               tx_sh_n       = sel_data[6:0];
               sdo_n         = sel_data[7];
               last_n        = sel_last;
               tx_ack_n[win] = 1'b1;
               ptr_n         = PW'((int'(win) + 1) % NREQ);
               cnt_n         = '0;
               bit_n         = '0;
               state_n       = S_LOW;
            end
         end
         S_LOW: begin
            if (cnt == DIV_M1) begin
               cnt_n   = '0;
               sclk_n  = 1'b1;
               rx_sh_n = {rx_sh[6:0], bus.sdi_i};
               state_n = S_HIGH;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         S_HIGH: begin
            if (cnt == DIV_M1) begin
               cnt_n  = '0;
               sclk_n = 1'b0;
               if (bit_cnt != 3'd7) begin
                  bit_n   = bit_cnt + 3'd1;
                  sdo_n   = tx_sh[6];
                  tx_sh_n = {tx_sh[5:0], 1'b0};
                  state_n = S_LOW;
               end else begin
                  bit_n            = '0;
                  rx_data_n        = rx_sh;
                  rx_valid_n[gidx] = 1'b1;
                  if (!last) begin
                     // Back-to-back byte: SS stays low, next byte starts with its MSb.
                     tx_sh_n        = sel_data[6:0];
                     sdo_n          = sel_data[7];
                     last_n         = sel_last;
                     tx_ack_n[gidx] = 1'b1;
                     state_n        = S_LOW;
                  end else begin
                     state_n = S_END;
                  end
               end
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         S_END: begin
            if (cnt == DIV_M1) begin
               cnt_n   = '0;
               ss_n    = 1'b1;
               gnt_n   = '0;
               state_n = S_GAP;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         S_GAP: begin
            if (cnt == GAP_M1) begin
               cnt_n   = '0;
               busy_n  = 1'b0;
               state_n = S_IDLE;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         rx_data  <= '0;
         last     <= 1'b0;
         gidx     <= '0;
         ptr      <= '0;
         gnt      <= '0;
         tx_ack   <= '0;
         rx_valid <= '0;
         sclk     <= 1'b0;
         ss       <= 1'b1;
         sdo      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         bit_cnt  <= bit_n;
         tx_sh    <= tx_sh_n;
         rx_sh    <= rx_sh_n;
         rx_data  <= rx_data_n;
         last     <= last_n;
         gidx     <= gidx_n;
         ptr      <= ptr_n;
         gnt      <= gnt_n;
         tx_ack   <= tx_ack_n;
         rx_valid <= rx_valid_n;
         sclk     <= sclk_n;
         ss       <= ss_n;
         sdo      <= sdo_n;
         busy     <= busy_n;
      end
   end

   assign bus.gnt_o      = gnt;
   assign bus.tx_ack_o   = tx_ack;
   assign bus.rx_valid_o = rx_valid;
   assign bus.rx_data_o  = rx_data;
   assign bus.busy_o     = busy;
   assign bus.sclk_o     = sclk;
   assign bus.ss_o       = ss;
   assign bus.sdo_o      = sdo;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench: one CLK_DIV=4 arbiter with requester/slave models, one CLK_DIV=1 instance.
module tb_spi_master_arbiter;
   localparam int NREQ = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_master_arbiter_if #(.NREQ(NREQ)) bus ();
   spi_master_arbiter_if #(.NREQ(NREQ)) bus1 ();

   spi_master_arbiter #(.NREQ(NREQ), .CLK_DIV(4), .SS_GAP(2)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus));
   spi_master_arbiter #(.NREQ(NREQ), .CLK_DIV(1), .SS_GAP(2)) dut1 (
      .clk_i(clk), .rst_i(rst), .bus(bus1));

   int checks = 0;
   int passes = 0;

   // requester and slave models
   logic       loop;
   logic [7:0] slave_byte;
   logic [7:0] bytes [NREQ][4];
   int         nb [NREQ];
   int         p [NREQ];
   logic [2:0] bit_in;

   always_comb begin
      bus.tx_data_i = '0;
      bus.tx_last_i = '0;
      for (int r = 0; r < NREQ; r++) begin
         bus.tx_data_i[8*r +: 8] = bytes[r][p[r]];
         bus.tx_last_i[r]        = (p[r] == nb[r] - 1);
      end
   end
   assign bus.sdi_i  = loop ? bus.sdo_o : slave_byte[~bit_in];
   assign bus1.sdi_i = bus1.sdo_o;

   // monitors
   int clr_req = 0, clr_seen = 0;
   wire clr = (clr_req != clr_seen);
   logic sclk_d, ss_d, sdo_d;
   logic [NREQ-1:0] gnt_d;
   wire rise = bus.sclk_o && !sclk_d;
   int rises, ss_low, ss_falls, gap_cnt, gnt_n, rx_n, viol = 0;
   logic [31:0] mosi;
   int ack_cnt [NREQ];
   int rxv_cnt [NREQ];
   int gnt_log [8];
   logic [7:0] rx_log [8];
   logic sclk1_d;
   int rises1, ss_low1, sclk_hi1, rxv1;
   logic [7:0] rxd1;

   function automatic int oh_idx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(negedge clk) begin
      clr_seen <= clr_req;
      sclk_d   <= bus.sclk_o;
      ss_d     <= bus.ss_o;
      sdo_d    <= bus.sdo_o;
      gnt_d    <= bus.gnt_o;
      if (bus.ss_o) bit_in <= 3'd0;
      else if (rise) bit_in <= bit_in + 3'd1;
      if ((bus.sdo_o !== sdo_d && bus.sclk_o) || (bus.ss_o && bus.sclk_o)) viol <= viol + 1;
      if (clr) begin
         rises <= 0; ss_low <= 0; ss_falls <= 0; gap_cnt <= 0; gnt_n <= 0; rx_n <= 0;
         mosi <= '0;
         for (int r = 0; r < NREQ; r++) begin
            ack_cnt[r] <= 0; rxv_cnt[r] <= 0; p[r] <= 0;
         end
      end else begin
         if (rise) begin
            rises <= rises + 1;
            mosi  <= {mosi[30:0], bus.sdo_o};
         end
         if (!bus.ss_o) ss_low <= ss_low + 1;
         if (!bus.ss_o && ss_d) ss_falls <= ss_falls + 1;
         if (bus.ss_o && bus.busy_o) gap_cnt <= gap_cnt + 1;
         if (bus.gnt_o != '0 && gnt_d == '0) begin
            if (gnt_n < 8) gnt_log[gnt_n] <= oh_idx(bus.gnt_o);
            gnt_n <= gnt_n + 1;
         end
         if (|bus.rx_valid_o) begin
            if (rx_n < 8) rx_log[rx_n] <= bus.rx_data_o;
            rx_n <= rx_n + 1;
         end
         for (int r = 0; r < NREQ; r++) begin
            if (bus.tx_ack_o[r]) begin
               ack_cnt[r] <= ack_cnt[r] + 1;
               p[r]       <= (p[r] + 1 == nb[r]) ? 0 : p[r] + 1;
            end
            if (bus.rx_valid_o[r]) rxv_cnt[r] <= rxv_cnt[r] + 1;
         end
      end
   end

   always @(negedge clk) begin
      sclk1_d <= bus1.sclk_o;
      if (clr) begin
         rises1 <= 0; ss_low1 <= 0; sclk_hi1 <= 0; rxv1 <= 0; rxd1 <= '0;
      end else begin
         if (bus1.sclk_o && !sclk1_d) rises1 <= rises1 + 1;
         if (!bus1.ss_o) ss_low1 <= ss_low1 + 1;
         if (bus1.sclk_o) sclk_hi1 <= sclk_hi1 + 1;
         if (|bus1.rx_valid_o) begin
            rxv1 <= rxv1 + 1;
            rxd1 <= bus1.rx_data_o;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clear_mon();
      clr_req++;
      @(negedge clk);
   endtask

   task automatic wait_busy(input int which, input logic v, input string tag);
      int n = 0;
      while (((which == 0) ? bus.busy_o : bus1.busy_o) !== v && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, (which == 0) ? bus.busy_o : bus1.busy_o, v);
   endtask

   task automatic wait_gnts(input int k, input string tag);
      int n = 0;
      while (gnt_n < k && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, gnt_n >= k, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      loop = 1'b1;
      slave_byte = 8'h00;
      bus.req_i = '0;
      bus1.req_i = '0;
      bus1.tx_data_i = '0;
      bus1.tx_last_i = '0;
      for (int r = 0; r < NREQ; r++) begin
         nb[r] = 1;
         for (int b = 0; b < 4; b++) bytes[r][b] = 8'h00;
      end

      // reset state
      @(negedge clk);
      chk("rst_ss", bus.ss_o, 1);
      chk("rst_sclk", bus.sclk_o, 0);
      chk("rst_sdo", bus.sdo_o, 0);
      chk("rst_gnt", bus.gnt_o, 0);
      chk("rst_ack", bus.tx_ack_o, 0);
      chk("rst_rxv", bus.rx_valid_o, 0);
      chk("rst_rxd", bus.rx_data_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      rst = 1'b0;
      clear_mon();

      // single byte, loopback
      bytes[0][0] = 8'hA5;
      clear_mon();
      bus.req_i = 4'b0001;
      wait_busy(0, 1, "t1_start");
      bus.req_i = '0;
      wait_busy(0, 0, "t1_done");
      @(negedge clk);
      chk("t1_sclk_pulses", rises, 8);
      chk("t1_ss_low", ss_low, 68);
      chk("t1_ss_falls", ss_falls, 1);
      chk("t1_mosi", mosi[7:0], 8'hA5);
      chk("t1_rxv", rxv_cnt[0], 1);
      chk("t1_rxd", rx_log[0], 8'hA5);
      chk("t1_ack", ack_cnt[0], 1);

      // three bytes on requester 1, slave returns 0x3C
      loop = 1'b0;
      slave_byte = 8'h3C;
      bytes[1][0] = 8'h01; bytes[1][1] = 8'h80; bytes[1][2] = 8'hFF;
      nb[1] = 3;
      clear_mon();
      bus.req_i = 4'b0010;
      wait_busy(0, 1, "t2_start");
      bus.req_i = '0;
      wait_busy(0, 0, "t2_done");
      @(negedge clk);
      chk("t2_mosi", mosi[23:0], 24'h0180FF);
      chk("t2_ack", ack_cnt[1], 3);
      chk("t2_rxv", rxv_cnt[1], 3);
      chk("t2_rx0", rx_log[0], 8'h3C);
      chk("t2_rx1", rx_log[1], 8'h3C);
      chk("t2_rx2", rx_log[2], 8'h3C);
      chk("t2_ss_low", ss_low, 196);
      chk("t2_ss_falls", ss_falls, 1);
      chk("t2_sclk_pulses", rises, 24);
      nb[1] = 1;
      loop = 1'b1;

      // asynchronous reset during bit 4
      bytes[0][0] = 8'hC3;
      clear_mon();
      bus.req_i = 4'b0001;
      begin
         int n = 0;
         while (rises < 5 && n < 3000) begin
            @(negedge clk);
            n++;
         end
      end
      chk("rs_bit4_reached", rises, 5);
      chk("rs_sclk_before", bus.sclk_o, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rs_ss", bus.ss_o, 1);
      chk("rs_sclk", bus.sclk_o, 0);
      chk("rs_gnt", bus.gnt_o, 0);
      chk("rs_busy", bus.busy_o, 0);
      bus.req_i = '0;
      @(negedge clk);
      rst = 1'b0;
      chk("rs_no_rxv", rxv_cnt[0], 0);

      // arbitration from a reset pointer: 0 then 2
      bytes[0][0] = 8'h11;
      bytes[2][0] = 8'h22;
      clear_mon();
      bus.req_i = 4'b0101;
      wait_gnts(2, "arb_two_grants");
      bus.req_i = '0;
      wait_busy(0, 0, "arb_done");
      @(negedge clk);
      chk("arb_first", gnt_log[0], 0);
      chk("arb_second", gnt_log[1], 2);
      chk("arb_ss_falls", ss_falls, 2);
      chk("arb_ss_low", ss_low, 136);
      chk("arb_gap", gap_cnt, 4);
      chk("arb_rx0", rx_log[0], 8'h11);
      chk("arb_rx1", rx_log[1], 8'h22);

      // fairness with all requesters held
      do_reset();
      for (int r = 0; r < NREQ; r++) bytes[r][0] = 8'h40 + 8'(r);
      clear_mon();
      bus.req_i = 4'b1111;
      wait_gnts(5, "fair_five_grants");
      bus.req_i = '0;
      wait_busy(0, 0, "fair_done");
      @(negedge clk);
      chk("fair_g0", gnt_log[0], 0);
      chk("fair_g1", gnt_log[1], 1);
      chk("fair_g2", gnt_log[2], 2);
      chk("fair_g3", gnt_log[3], 3);
      chk("fair_g4", gnt_log[4], 0);
      chk("fair_rxv0", rxv_cnt[0], 2);
      chk("fair_rxv3", rxv_cnt[3], 1);
      chk("fair_rx3", rx_log[3], 8'h43);

      // CLK_DIV=1 instance
      bus1.tx_data_i[7:0] = 8'h5A;
      bus1.tx_last_i[0] = 1'b1;
      clear_mon();
      bus1.req_i = 4'b0001;
      wait_busy(1, 1, "d1_start");
      bus1.req_i = '0;
      wait_busy(1, 0, "d1_done");
      @(negedge clk);
      chk("d1_sclk_pulses", rises1, 8);
      chk("d1_sclk_high", sclk_hi1, 8);
      chk("d1_ss_low", ss_low1, 17);
      chk("d1_rxv", rxv1, 1);
      chk("d1_rxd", rxd1, 8'h5A);

      chk("pin_rules", viol, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
